// File: rtl/hazard_sequencer.sv
// Hazard controller for the LEGv8 5-stage pipeline: load-use bubbles, multi-cycle
// MUL occupancy stalls, taken-branch IF/ID flush and a saturating stall-cycle counter.
module hazard_sequencer #(
    parameter int MUL_LATENCY = 4,
    parameter int PERF_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        IFID_RegisterRn,
    input  logic [4:0]        IFID_RegisterRm,
    input  logic              IFID_uses_Rm,
    input  logic              IDEX_MemRead,
    input  logic [4:0]        IDEX_RegisterRd,
    input  logic              mul_start,
    input  logic              IF_Flush,
    output logic              PCWrite,
    output logic              IFID_Write,
    output logic              ctrl_bubble,
    output logic              IFID_Flush,
    output logic              mul_busy,
    output logic [PERF_W-1:0] stall_count
);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] MUL_BUSY = 1'b1;

    // Occupancy after the issue cycle is MUL_LATENCY-1 cycles; cnt counts down to 0.
    localparam bit         MUL_MULTI  = (MUL_LATENCY > 1);
    localparam int         RELOAD     = (MUL_LATENCY > 1) ? (MUL_LATENCY - 2) : 0;
    localparam logic [3:0] MUL_RELOAD = RELOAD[3:0];

    logic [0:0] state;
    logic [0:0] state_next;
    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic       load_use;

    // XZR (register 31) is never a real producer.
    assign load_use = IDEX_MemRead && (IDEX_RegisterRd != 5'd31) &&
                      ((IDEX_RegisterRd == IFID_RegisterRn) ||
                       (IFID_uses_Rm && (IDEX_RegisterRd == IFID_RegisterRm)));

    always_comb begin
        PCWrite     = 1'b1;
        IFID_Write  = 1'b1;
        ctrl_bubble = 1'b0;
        IFID_Flush  = 1'b0;
        mul_busy    = 1'b0;
        state_next  = state;
        cnt_next    = cnt;
        if (!reset) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            ctrl_bubble = 1'b1;
            state_next  = IDLE;
            cnt_next    = 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_use) begin
                        PCWrite     = 1'b0;
                        IFID_Write  = 1'b0;
                        ctrl_bubble = 1'b1;
                    end else if (mul_start) begin
                        IFID_Flush = IF_Flush;
                        if (MUL_MULTI) begin
                            state_next = MUL_BUSY;
                            cnt_next   = MUL_RELOAD;
                        end
                    end else begin
                        IFID_Flush = IF_Flush;
                    end
                end
                MUL_BUSY: begin
                    PCWrite     = 1'b0;
                    IFID_Write  = 1'b0;
                    ctrl_bubble = 1'b1;
                    mul_busy    = 1'b1;
                    if (cnt == 4'd0) begin
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt - 4'd1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (!PCWrite && (stall_count != {PERF_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: three instances (latency 4, latency 1,
// latency 15 with a 4-bit counter) share stimulus and are checked against a cycle model.
module tb_hazard_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [4:0] rn, rm, rd;
    logic       uses_rm, memread, mul_start, if_flush;

    logic [2:0]  pcw, ifw, bub, flo, mbz;
    logic [15:0] sc_a, sc_b;
    logic [3:0]  sc_c;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [20:0] exp_a[$];
    logic [20:0] exp_b[$];
    logic [20:0] exp_c[$];

    int ml[3]    = '{4, 1, 15};
    int pmax[3]  = '{65535, 65535, 15};
    int busy_left[3];
    int perf[3];

    hazard_sequencer #(.MUL_LATENCY(4), .PERF_W(16)) dut_a (
        .clk(clk), .reset(reset),
        .IFID_RegisterRn(rn), .IFID_RegisterRm(rm), .IFID_uses_Rm(uses_rm),
        .IDEX_MemRead(memread), .IDEX_RegisterRd(rd),
        .mul_start(mul_start), .IF_Flush(if_flush),
        .PCWrite(pcw[0]), .IFID_Write(ifw[0]), .ctrl_bubble(bub[0]),
        .IFID_Flush(flo[0]), .mul_busy(mbz[0]), .stall_count(sc_a)
    );

    hazard_sequencer #(.MUL_LATENCY(1), .PERF_W(16)) dut_b (
        .clk(clk), .reset(reset),
        .IFID_RegisterRn(rn), .IFID_RegisterRm(rm), .IFID_uses_Rm(uses_rm),
        .IDEX_MemRead(memread), .IDEX_RegisterRd(rd),
        .mul_start(mul_start), .IF_Flush(if_flush),
        .PCWrite(pcw[1]), .IFID_Write(ifw[1]), .ctrl_bubble(bub[1]),
        .IFID_Flush(flo[1]), .mul_busy(mbz[1]), .stall_count(sc_b)
    );

    hazard_sequencer #(.MUL_LATENCY(15), .PERF_W(4)) dut_c (
        .clk(clk), .reset(reset),
        .IFID_RegisterRn(rn), .IFID_RegisterRm(rm), .IFID_uses_Rm(uses_rm),
        .IDEX_MemRead(memread), .IDEX_RegisterRd(rd),
        .mul_start(mul_start), .IF_Flush(if_flush),
        .PCWrite(pcw[2]), .IFID_Write(ifw[2]), .ctrl_bubble(bub[2]),
        .IFID_Flush(flo[2]), .mul_busy(mbz[2]), .stall_count(sc_c)
    );

    function automatic void push_exp(input int i, input logic [20:0] v);
        case (i)
            0:       exp_a.push_back(v);
            1:       exp_b.push_back(v);
            default: exp_c.push_back(v);
        endcase
    endfunction

    // Drive one cycle of inputs, then predict this cycle's outputs and the next edge's effect.
    task automatic step(input logic r, input logic [4:0] a_rn, input logic [4:0] a_rm,
                        input logic a_urm, input logic a_mr, input logic [4:0] a_rd,
                        input logic a_mul, input logic a_fl);
        logic lu, e_pc, e_ifw, e_bub, e_fl, e_mb;
        int   e_cnt;
        @(posedge clk);
        #1;
        reset = r; rn = a_rn; rm = a_rm; uses_rm = a_urm;
        memread = a_mr; rd = a_rd; mul_start = a_mul; if_flush = a_fl;
        lu = a_mr && (a_rd != 5'd31) && ((a_rd == a_rn) || (a_urm && (a_rd == a_rm)));
        for (int i = 0; i < 3; i++) begin
            if (!r) begin
                busy_left[i] = 0;
                perf[i] = 0;
                push_exp(i, {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0});
            end else begin
                e_fl = 1'b0; e_mb = 1'b0;
                if (busy_left[i] > 0) begin
                    e_pc = 1'b0; e_ifw = 1'b0; e_bub = 1'b1; e_mb = 1'b1;
                end else if (lu) begin
                    e_pc = 1'b0; e_ifw = 1'b0; e_bub = 1'b1;
                end else begin
                    e_pc = 1'b1; e_ifw = 1'b1; e_bub = 1'b0; e_fl = a_fl;
                end
                e_cnt = perf[i];
                push_exp(i, {e_pc, e_ifw, e_bub, e_fl, e_mb, e_cnt[15:0]});
                if (!e_pc && perf[i] < pmax[i]) perf[i] = perf[i] + 1;
                if (busy_left[i] > 0) busy_left[i] = busy_left[i] - 1;
                else if (!lu && a_mul) busy_left[i] = ml[i] - 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    function automatic logic [20:0] actual(input int i);
        case (i)
            0:       return {pcw[0], ifw[0], bub[0], flo[0], mbz[0], sc_a};
            1:       return {pcw[1], ifw[1], bub[1], flo[1], mbz[1], sc_b};
            default: return {pcw[2], ifw[2], bub[2], flo[2], mbz[2], 12'd0, sc_c};
        endcase
    endfunction

    // Monitor: one comparison per instance each cycle that has a pending expectation.
    always @(negedge clk) begin
        logic [20:0] got, want;
        logic        have;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            have = 1'b0;
            want = '0;
            case (i)
                0: if (exp_a.size() > 0) begin want = exp_a.pop_front(); have = 1'b1; end
                1: if (exp_b.size() > 0) begin want = exp_b.pop_front(); have = 1'b1; end
                default: if (exp_c.size() > 0) begin want = exp_c.pop_front(); have = 1'b1; end
            endcase
            if (have) begin
                got = actual(i);
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL inst%0d cycle %0d: got pc=%b ifw=%b bub=%b fl=%b mb=%b cnt=%0d, want pc=%b ifw=%b bub=%b fl=%b mb=%b cnt=%0d",
                             i, cyc, got[20], got[19], got[18], got[17], got[16], got[15:0],
                             want[20], want[19], want[18], want[17], want[16], want[15:0]);
                end
            end
        end
    end

    initial begin
        reset = 1'b0; rn = '0; rm = '0; rd = '0;
        uses_rm = 1'b0; memread = 1'b0; mul_start = 1'b0; if_flush = 1'b0;
        for (int i = 0; i < 3; i++) begin busy_left[i] = 0; perf[i] = 0; end

        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        idle(3);
        step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        idle(2);
        // load-use on Rn, then XZR and unused-Rm cases, then a real Rm hazard
        step(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
        idle(1);
        step(1'b1, 5'd31, 5'd5, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0);
        step(1'b1, 5'd1, 5'd3, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
        step(1'b1, 5'd1, 5'd3, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
        idle(1);
        step(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
        idle(16);
        step(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
        idle(1);
        // flush held off by a load-use, taken the following cycle
        step(1'b1, 5'd3, 5'd0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1);
        step(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
        step(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
        idle(16);
        // reset during the second busy cycle aborts the occupancy
        step(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
        idle(1);
        step(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        idle(3);
        // long back-to-back MUL stalls drive the 4-bit counter into saturation
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
            idle(14);
        end
        idle(2);
        for (int k = 0; k < 400; k++) begin
            logic [4:0] r_rn, r_rm, r_rd;
            r_rn = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
            r_rm = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
            r_rd = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
            step(($urandom_range(0, 49) != 0), r_rn, r_rm, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), r_rd, ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0));
        end
        idle(2);
        for (int k = 0; k < 10; k++) begin
            if (exp_a.size() == 0 && exp_b.size() == 0 && exp_c.size() == 0) break;
            @(negedge clk);
        end
        @(negedge clk);
        #1;
        total++;
        if (exp_a.size() + exp_b.size() + exp_c.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expectations, want 0",
                     exp_a.size() + exp_b.size() + exp_c.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
